cgol_step_scheduler: RTL and testbench

Sequences all state changes of the Conway game-of-life grid so they happen only during VGA vertical blanking. It shares the grid's single update path between three requesters: generation stepping (free-run or single-step), preset loading, and cursor cell writes. It sits between the switch, button and accelerometer-cursor logic and the grid. It paces generations in whole video frames and tracks the generation count.

---
 rtl/cgol_step_scheduler_if.sv | 43 ++++
 rtl/cgol_step_scheduler.sv | 245 ++++++++++++++++++++++++
 tb/tb_cgol_step_scheduler.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cgol_step_scheduler_if.sv
// ---------------------------------------------------------------------------
// cgol_step_scheduler_if
//
// Update bus between the step scheduler and the game-of-life grid. It carries
// every state-changing request the grid can receive, plus the grid's
// generation-finished pulse.
//
//   gen_step     scheduler -> grid  one-cycle pulse, compute one generation
//   load_strobe  scheduler -> grid  one-cycle pulse, load preset load_id
//   load_id      scheduler -> grid  preset id, valid with load_strobe
//   cell_we      scheduler -> grid  one-cycle single-cell write strobe
//   cell_row     scheduler -> grid  write row, valid with cell_we
//   cell_col     scheduler -> grid  write column, valid with cell_we
//   cell_val     scheduler -> grid  write value, valid with cell_we
//   gen_done     grid -> scheduler  one-cycle pulse, generation finished
//
// master: the scheduler side. slave: the grid side.
// ---------------------------------------------------------------------------
interface cgol_step_scheduler_if #(
    parameter int ROW_W = 6,
    parameter int COL_W = 6
);
    logic             gen_step;
    logic             load_strobe;
    logic [1:0]       load_id;
    logic             cell_we;
    logic [ROW_W-1:0] cell_row;
    logic [COL_W-1:0] cell_col;
    logic             cell_val;
    logic             gen_done;

    modport master (
        output gen_step, load_strobe, load_id,
        output cell_we, cell_row, cell_col, cell_val,
        input  gen_done
    );

    modport slave (
        input  gen_step, load_strobe, load_id,
        input  cell_we, cell_row, cell_col, cell_val,
        output gen_done
    );
endinterface

// File: rtl/cgol_step_scheduler.sv
// ---------------------------------------------------------------------------
// cgol_step_scheduler
//
// Serialises every change to the game-of-life grid into vertical blanking.
// One action is granted per frame_end while idle, with fixed priority
// preset load > generation step > user cell write. Generations are paced in
// whole frames (free-run divider) or requested one at a time by a button.
//
// Ports:
//   clk         system (pixel) clock
//   reset       synchronous, active-high reset
//   frame_end   one-cycle pulse at start of vertical blanking
//   run_en      level, free-running generations enabled
//   step_btn    level, rising edge requests one generation
//   speed_sel   frames-per-generation select (DIV0..DIV3)
//   preset_req  level, rising edge requests a preset load
//   preset_id   preset to load, captured on the preset_req rising edge
//   wr_req      level, user cell-write enable
//   wr_row/wr_col/wr_val  cursor position and value to write
//   grid        update bus to the grid (master side)
//   gen_count   generations completed since reset or last preset load
//   state       FSM state: 0 IDLE, 1 STEP, 2 WAIT, 3 LOAD
//   err         sticky, set when the grid fails to report gen_done in time
// ---------------------------------------------------------------------------
module cgol_step_scheduler #(
    parameter int ROWS    = 30,
    parameter int COLS    = 40,
    parameter int ROW_W   = 6,
    parameter int COL_W   = 6,
    parameter int DIV0    = 60,
    parameter int DIV1    = 30,
    parameter int DIV2    = 15,
    parameter int DIV3    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_end,
    input  logic                   run_en,
    input  logic                   step_btn,
    input  logic [1:0]             speed_sel,
    input  logic                   preset_req,
    input  logic [1:0]             preset_id,
    input  logic                   wr_req,
    input  logic [ROW_W-1:0]       wr_row,
    input  logic [COL_W-1:0]       wr_col,
    input  logic                   wr_val,
    cgol_step_scheduler_if.master  grid,
    output logic [15:0]            gen_count,
    output logic [1:0]             state,
    output logic                   err
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_WAIT = 2'd2,
        S_LOAD = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_next;

    logic                step_prev;
    logic                preset_prev;
    logic [1:0]          speed_prev;
    logic                step_pending;
    logic                preset_pending;
    logic [1:0]          preset_id_q;
    logic                auto_due;
    logic [7:0]          fc;
    logic [WAIT_W-1:0]   wait_cnt;

    logic                step_rise;
    logic                preset_rise;
    logic                speed_changed;
    logic [7:0]          div_sel;
    logic                fc_last;
    logic                auto_hit;
    logic                step_due;
    logic                wr_ok;
    logic                grant_step;
    logic                grant_load;
    logic                grant_wr;
    logic                done_ok;
    logic                timeout_hit;

    assign state = state_q;

    // ---------------------------------------------------------------------
    // Request qualification
    // ---------------------------------------------------------------------
    assign step_rise     = step_btn & ~step_prev;
    assign preset_rise   = preset_req & ~preset_prev;
    assign speed_changed = (speed_sel != speed_prev);

    always_comb begin
        case (speed_sel)
            2'd0:    div_sel = 8'(DIV0);
            2'd1:    div_sel = 8'(DIV1);
            2'd2:    div_sel = 8'(DIV2);
            default: div_sel = 8'(DIV3);
        endcase
    end

    assign fc_last = (fc == div_sel - 8'd1);

    // The divider wrap in this very frame already counts as due, so a step
    // lands one cycle after the Nth frame_end rather than a frame later.
    assign auto_hit = frame_end & run_en & ~speed_changed & fc_last;
    assign step_due = auto_due | auto_hit | step_pending;

    // Extra leading zero keeps the compare correct even if ROWS == 2**ROW_W.
    assign wr_ok = wr_req
                 & ({1'b0, wr_row} < (ROW_W + 1)'(ROWS))
                 & ({1'b0, wr_col} < (COL_W + 1)'(COLS));

    // ---------------------------------------------------------------------
    // FSM next-state and grant decode
    // ---------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next  = state_q;
        grant_step  = 1'b0;
        grant_load  = 1'b0;
        grant_wr    = 1'b0;
        done_ok     = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_end) begin
                    if (preset_pending) begin
                        state_next = S_LOAD;
                        grant_load = 1'b1;
                    end else if (step_due) begin
                        state_next = S_STEP;
                        grant_step = 1'b1;
                    end else if (wr_ok) begin
                        grant_wr   = 1'b1;
                    end
                end
            end
            S_STEP: state_next = S_WAIT;
            S_WAIT: begin
                if (grid.gen_done) begin
                    state_next = S_IDLE;
                    done_ok    = 1'b1;
                end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
                    state_next  = S_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State, strobes and bookkeeping
    // ---------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        // Edge detectors follow the input even in reset, so a level held
        // high through reset is not mistaken for a fresh edge afterwards.
        step_prev   <= step_btn;
        preset_prev <= preset_req;
        speed_prev  <= speed_sel;

        if (reset) begin
            state_q          <= S_IDLE;
            grid.gen_step    <= 1'b0;
            grid.load_strobe <= 1'b0;
            grid.load_id     <= 2'd0;
            grid.cell_we     <= 1'b0;
            grid.cell_row    <= '0;
            grid.cell_col    <= '0;
            grid.cell_val    <= 1'b0;
            gen_count        <= 16'd0;
            err              <= 1'b0;
            fc               <= 8'd0;
            auto_due         <= 1'b0;
            step_pending     <= 1'b0;
            preset_pending   <= 1'b0;
            preset_id_q      <= 2'd0;
            wait_cnt         <= '0;
        end else begin
            state_q          <= state_next;
            grid.gen_step    <= grant_step;
            grid.load_strobe <= grant_load;
            grid.cell_we     <= grant_wr;

            if (grant_load) begin
                grid.load_id <= preset_id_q;
            end
            if (grant_wr) begin
                grid.cell_row <= wr_row;
                grid.cell_col <= wr_col;
                grid.cell_val <= wr_val;
            end

            // Only counts while in WAIT; restarts from 0 on every entry.
            wait_cnt <= (state_q == S_WAIT) ? wait_cnt + 1'b1 : '0;

            if (grant_load) begin
                gen_count <= 16'd0;
            end else if (done_ok) begin
                gen_count <= gen_count + 16'd1;
            end

            if (timeout_hit) begin
                err <= 1'b1;
            end

            if (speed_changed) begin
                fc <= 8'd0;
            end else if (frame_end && run_en) begin
                fc <= fc_last ? 8'd0 : fc + 8'd1;
            end

            if (grant_step) begin
                auto_due <= 1'b0;
            end else if (auto_hit) begin
                auto_due <= 1'b1;
            end

            // A new edge wins over a same-cycle grant so a press is never lost.
            if (step_rise) begin
                step_pending <= 1'b1;
            end else if (grant_step) begin
                step_pending <= 1'b0;
            end

            if (preset_rise) begin
                preset_pending <= 1'b1;
                preset_id_q    <= preset_id;
            end else if (grant_load) begin
                preset_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cgol_step_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cgol_step_scheduler
//
// Directed bench for cgol_step_scheduler. A small grid responder answers
// gen_step with gen_done a fixed number of cycles later (when enabled).
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// at the same point, i.e. they show the registers loaded by that edge.
// ---------------------------------------------------------------------------
module tb_cgol_step_scheduler;

    localparam int ROWS    = 30;
    localparam int COLS    = 40;
    localparam int ROW_W   = 6;
    localparam int COL_W   = 6;
    localparam int TIMEOUT = 1023;

    logic             clk = 1'b0;
    logic             reset;
    logic             frame_end;
    logic             run_en;
    logic             step_btn;
    logic [1:0]       speed_sel;
    logic             preset_req;
    logic [1:0]       preset_id;
    logic             wr_req;
    logic [ROW_W-1:0] wr_row;
    logic [COL_W-1:0] wr_col;
    logic             wr_val;
    logic [15:0]      gen_count;
    logic [1:0]       state;
    logic             err;

    cgol_step_scheduler_if #(.ROW_W(ROW_W), .COL_W(COL_W)) grid ();

    cgol_step_scheduler #(
        .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
        .DIV0(60), .DIV1(30), .DIV2(15), .DIV3(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_end  (frame_end),
        .run_en     (run_en),
        .step_btn   (step_btn),
        .speed_sel  (speed_sel),
        .preset_req (preset_req),
        .preset_id  (preset_id),
        .wr_req     (wr_req),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_val     (wr_val),
        .grid       (grid.master),
        .gen_count  (gen_count),
        .state      (state),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Grid responder and strobe counters, evaluated mid-cycle.
    logic gd_en    = 1'b0;
    logic gd_force = 1'b0;
    int   gd_timer = -1;
    int   n_gen_step = 0;
    int   n_we       = 0;

    initial grid.gen_done = 1'b0;

    always @(negedge clk) begin
        logic fire;
        fire = 1'b0;
        if (gd_timer > 0) begin
            gd_timer--;
            if (gd_timer == 0) begin
                fire = 1'b1;
                gd_timer = -1;
            end
        end
        if (grid.gen_step === 1'b1) begin
            n_gen_step++;
            if (gd_en) gd_timer = 5;
        end
        if (grid.cell_we === 1'b1) n_we++;
        grid.gen_done = fire | gd_force;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic frame();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic press_step();
        step_btn = 1'b1;
        tick();
        step_btn = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_before;
        int we_before;

        reset = 1'b1; frame_end = 1'b0; run_en = 1'b0; step_btn = 1'b0;
        speed_sel = 2'd3; preset_req = 1'b0; preset_id = 2'd0;
        wr_req = 1'b0; wr_row = '0; wr_col = '0; wr_val = 1'b0;
        idle(2);
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_state",     32'(state),            32'd0);
        check("rst_gen_count", 32'(gen_count),        32'd0);
        check("rst_err",       32'(err),              32'd0);
        check("rst_gen_step",  32'(grid.gen_step),    32'd0);
        check("rst_load",      32'(grid.load_strobe), 32'd0);
        check("rst_cell_we",   32'(grid.cell_we),     32'd0);
        check("rst_load_id",   32'(grid.load_id),     32'd0);
        check("rst_cell_row",  32'(grid.cell_row),    32'd0);

        // Free run at DIV3=4: steps after frames 4, 8, 12
        gd_en  = 1'b1;
        run_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            frame();
            check($sformatf("run_gen_step_f%0d", i + 1), 32'(grid.gen_step),
                  ((i % 4) == 3) ? 32'd1 : 32'd0);
            if (i == 3) check("run_state_step", 32'(state), 32'd1);
            idle(15);
        end
        run_en = 1'b0;
        check("run_gen_count", 32'(gen_count), 32'd3);
        check("run_n_steps",   32'(n_gen_step), 32'd3);
        check("run_state_idle", 32'(state), 32'd0);

        // Manual step: two presses, only one generation
        press_step();
        press_step();
        frame();
        check("man_step_f1", 32'(grid.gen_step), 32'd1);
        idle(15);
        frame();
        check("man_step_f2", 32'(grid.gen_step), 32'd0);
        idle(15);
        check("man_gen_count", 32'(gen_count), 32'd4);

        // Simultaneous preset, step and write
        we_before = n_we;
        press_step();
        preset_id = 2'd2; preset_req = 1'b1;
        tick();
        preset_req = 1'b0; preset_id = 2'd1;
        wr_req = 1'b1; wr_row = 6'd1; wr_col = 6'd1; wr_val = 1'b1;
        tick();
        frame();
        check("sim_load_strobe", 32'(grid.load_strobe), 32'd1);
        check("sim_load_id",     32'(grid.load_id),     32'd2);
        check("sim_gen_count",   32'(gen_count),        32'd0);
        check("sim_state_load",  32'(state),            32'd3);
        check("sim_step_f1",     32'(grid.gen_step),    32'd0);
        idle(3);
        frame();
        check("sim_step_f2",     32'(grid.gen_step),    32'd1);
        check("sim_we_f2",       32'(grid.cell_we),     32'd0);
        idle(15);
        wr_req = 1'b0;
        check("sim_no_we",       32'(n_we - we_before), 32'd0);
        check("sim_gen_count2",  32'(gen_count),        32'd1);

        // Write bounds
        wr_req = 1'b1; wr_row = 6'd29; wr_col = 6'd39; wr_val = 1'b1;
        frame();
        check("wr_max_we",  32'(grid.cell_we),  32'd1);
        check("wr_max_row", 32'(grid.cell_row), 32'd29);
        check("wr_max_col", 32'(grid.cell_col), 32'd39);
        check("wr_max_val", 32'(grid.cell_val), 32'd1);
        check("wr_state",   32'(state),         32'd0);
        tick();
        check("wr_we_single", 32'(grid.cell_we), 32'd0);
        wr_row = 6'd30; wr_col = 6'd5;
        frame();
        check("wr_row_oob_we",  32'(grid.cell_we),  32'd0);
        check("wr_row_oob_row", 32'(grid.cell_row), 32'd29);
        tick();
        wr_row = 6'd0; wr_col = 6'd40;
        frame();
        check("wr_col_oob_we", 32'(grid.cell_we), 32'd0);
        tick();
        wr_row = 6'd0; wr_col = 6'd0; wr_val = 1'b0;
        frame();
        check("wr_min_we",  32'(grid.cell_we),  32'd1);
        check("wr_min_col", 32'(grid.cell_col), 32'd0);
        check("wr_min_val", 32'(grid.cell_val), 32'd0);
        wr_req = 1'b0;
        tick();

        // Timeout: no gen_done ever arrives
        gd_en = 1'b0;
        cnt_before = 32'(gen_count);
        press_step();
        frame();
        check("to_gen_step", 32'(grid.gen_step), 32'd1);
        tick();
        check("to_state_wait", 32'(state), 32'd2);
        idle(TIMEOUT);
        check("to_err_before", 32'(err),   32'd0);
        check("to_still_wait", 32'(state), 32'd2);
        tick();
        check("to_err",        32'(err),       32'd1);
        check("to_state_idle", 32'(state),     32'd0);
        check("to_gen_count",  32'(gen_count), 32'(cnt_before));
        idle(3);

        // Reset mid-WAIT, with step_btn held high through reset
        press_step();
        frame();
        check("rw_gen_step", 32'(grid.gen_step), 32'd1);
        idle(3);
        check("rw_state_wait", 32'(state), 32'd2);
        step_btn = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rw_state",     32'(state),         32'd0);
        check("rw_gen_count", 32'(gen_count),     32'd0);
        check("rw_err",       32'(err),           32'd0);
        check("rw_gen_step0", 32'(grid.gen_step), 32'd0);
        gd_force = 1'b1;
        tick();
        gd_force = 1'b0;
        idle(2);
        check("rw_late_done", 32'(gen_count), 32'd0);
        frame();
        check("rw_held_btn", 32'(grid.gen_step), 32'd0);
        step_btn = 1'b0;
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
